// File: rtl/q_update_engine_if.sv
// Request/RAM bundle for the Q-learning write-back engine.
// The engine sits on the slave modport; the requester and Q-table RAM sit on the master side.
interface q_update_engine_if #(
  parameter int STATE_W = 6
);
  logic               upd_valid;
  logic               upd_ready;
  logic [STATE_W-1:0] upd_state;
  logic [3:0]         upd_action;
  logic [15:0]        upd_reward;
  logic [15:0]        upd_max_q;
  logic [STATE_W+3:0] q_addr;
  logic               q_rd_en;
  logic [15:0]        q_rd_data;
  logic               q_we;
  logic [15:0]        q_wr_data;
  logic               upd_done;
  logic               upd_err;

  modport master (
    output upd_valid, upd_state, upd_action, upd_reward, upd_max_q, q_rd_data,
    input  upd_ready, q_addr, q_rd_en, q_we, q_wr_data, upd_done, upd_err
  );

  modport slave (
    input  upd_valid, upd_state, upd_action, upd_reward, upd_max_q, q_rd_data,
    output upd_ready, q_addr, q_rd_en, q_we, q_wr_data, upd_done, upd_err
  );
endinterface

// File: rtl/q_update_engine.sv
// Q-table write-back: Q(s,a) += alpha*(r + gamma*maxQ' - Q(s,a)) as a 4-cycle read-modify-write.
// Define QUPD_SATURATE_EN to clamp the result to 0..65535 instead of wrapping modulo 2^16.
module q_update_engine #(
  parameter int STATE_W     = 6,
  parameter int NUM_ACTIONS = 15,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  q_update_engine_if.slave    io_bus
);

  localparam logic [4:0] NUM_ACT_L = 5'(NUM_ACTIONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_live;
  logic [STATE_W+3:0] r_addr;
  logic [15:0]        r_reward;
  logic [15:0]        r_maxQ;
  logic [15:0]        r_result;

  logic               w_accept;
  logic               w_illegal;
  logic [16:0]        w_g;
  logic signed [18:0] w_target;
  logic signed [18:0] w_diff;
  logic signed [18:0] w_delta;
  logic [15:0]        w_result;

  assign w_accept  = io_bus.upd_valid && io_bus.upd_ready;
  assign w_illegal = ({1'b0, io_bus.upd_action} >= NUM_ACT_L);

  // r_live keeps upd_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_nextState       = r_state;
    io_bus.upd_ready  = 1'b0;
    io_bus.q_rd_en    = 1'b0;
    io_bus.q_we       = 1'b0;
    io_bus.upd_done   = 1'b0;
    io_bus.upd_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        io_bus.upd_ready = r_live;
        if (w_accept) begin
          w_nextState = w_illegal ? S_ERR : S_RD;
        end
      end
      S_RD: begin
        io_bus.q_rd_en = 1'b1;
        w_nextState    = S_CALC;
      end
      S_CALC: begin
        w_nextState = S_WR;
      end
      S_WR: begin
        io_bus.q_we     = 1'b1;
        io_bus.upd_done = 1'b1;
        w_nextState     = S_IDLE;
      end
      S_ERR: begin
        io_bus.upd_err = 1'b1;
        w_nextState    = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Request fields are frozen at accept so the requester may move on immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_reward <= '0;
      r_maxQ   <= '0;
    end else if (w_accept) begin
      r_addr   <= {io_bus.upd_state, io_bus.upd_action};
      r_reward <= io_bus.upd_reward;
      r_maxQ   <= io_bus.upd_max_q;
    end
  end

  assign w_g      = {1'b0, r_maxQ} - {1'b0, (r_maxQ >> GAMMA_SHIFT)};
  assign w_target = {{3{r_reward[15]}}, r_reward} + {2'b00, w_g};
  assign w_diff   = w_target - {3'b000, io_bus.q_rd_data};
  assign w_delta  = w_diff >>> ALPHA_SHIFT;

`ifdef QUPD_SATURATE_EN
  logic signed [19:0] w_new;
  assign w_new = {4'b0000, io_bus.q_rd_data} + {w_delta[18], w_delta};
  always_comb begin
    w_result = w_new[15:0];
    if (w_new[19]) begin
      w_result = 16'h0000;
    end else if (w_new[19:16] != 4'b0000) begin
      w_result = 16'hFFFF;
    end
  end
`else
  assign w_result = 16'({4'b0000, io_bus.q_rd_data} + {w_delta[18], w_delta});
`endif

  // The RAM returns q_old during CALC; the result is registered for the WR cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (r_state == S_CALC) begin
      r_result <= w_result;
    end
  end

  assign io_bus.q_addr    = r_addr;
  assign io_bus.q_wr_data = r_result;

endmodule

// File: tb/tb_q_update_engine.sv
// Directed, table-driven bench for q_update_engine with a 1-cycle-read Q-table RAM model.
// Expected write values follow QUPD_SATURATE_EN if defined for the build.
module tb_q_update_engine;

  localparam int STATE_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q_update_engine_if #(.STATE_W(STATE_W)) bus ();

  q_update_engine #(
    .STATE_W    (STATE_W),
    .NUM_ACTIONS(15),
    .ALPHA_SHIFT(2),
    .GAMMA_SHIFT(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus.slave)
  );

  typedef struct {
    string       name;
    logic [5:0]  st;
    logic [3:0]  act;
    logic [15:0] rew;
    logic [15:0] mq;
    logic [15:0] ramOld;
    logic        illegal;
    logic [15:0] expWr;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:1023];
  logic        preloadEn = 1'b0;
  logic [9:0]  preAddr = '0;
  logic [15:0] preData = '0;

  int cyc = 0;
  int rdCount = 0;
  int weCount = 0;
  int overlapCount = 0;
  int accCyc [$];
  int wrCyc [$];

  // Q-table RAM: synchronous read, data valid the cycle after q_rd_en
  always @(posedge clk) begin
    if (preloadEn) mem[preAddr] <= preData;
    if (bus.q_rd_en) bus.q_rd_data <= mem[bus.q_addr];
    if (bus.q_we) mem[bus.q_addr] <= bus.q_wr_data;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.q_rd_en) rdCount <= rdCount + 1;
    if (bus.q_we) weCount <= weCount + 1;
    if (bus.q_rd_en && bus.q_we) overlapCount <= overlapCount + 1;
    if (bus.upd_valid && bus.upd_ready) accCyc.push_back(cyc);
    if (bus.q_we) wrCyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic preload(input logic [9:0] addr, input logic [15:0] data);
    preloadEn = 1'b1;
    preAddr   = addr;
    preData   = data;
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
  endtask

  // Present a request, wait (bounded) for acceptance, then scramble the inputs
  task automatic applyStimulus(input vec_t v);
    bit ok;
    ok = 1'b0;
    bus.upd_valid  = 1'b1;
    bus.upd_state  = v.st;
    bus.upd_action = v.act;
    bus.upd_reward = v.rew;
    bus.upd_max_q  = v.mq;
    for (int i = 0; i < 20; i++) begin
      if (bus.upd_ready) begin
        ok = 1'b1;
        break;
      end
      waitNeg();
    end
    if (!ok) checkOutput({v.name, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    bus.upd_valid  = 1'b0;
    bus.upd_state  = ~v.st;
    bus.upd_action = 4'd0;
    bus.upd_reward = 16'h7FFF;
    bus.upd_max_q  = 16'hFFFF;
  endtask

  task automatic runVector(input vec_t v);
    int rd0;
    int we0;
    logic [9:0] addr;
    addr = {v.st, v.act};
    if (!v.illegal) preload(addr, v.ramOld);
    waitNeg();
    rd0 = rdCount;
    we0 = weCount;
    applyStimulus(v);
    waitNeg();
    if (v.illegal) begin
      checkOutput({v.name, "_err_t1"}, bus.upd_err, 1);
      checkOutput({v.name, "_rd_t1"}, bus.q_rd_en, 0);
      checkOutput({v.name, "_ready_t1"}, bus.upd_ready, 0);
      waitNeg();
      checkOutput({v.name, "_ready_t2"}, bus.upd_ready, 1);
      checkOutput({v.name, "_err_t2"}, bus.upd_err, 0);
      waitNeg();
      checkOutput({v.name, "_no_read"}, rdCount - rd0, 0);
      checkOutput({v.name, "_no_write"}, weCount - we0, 0);
    end else begin
      checkOutput({v.name, "_rd_t1"}, bus.q_rd_en, 1);
      checkOutput({v.name, "_addr_t1"}, bus.q_addr, addr);
      checkOutput({v.name, "_ready_t1"}, bus.upd_ready, 0);
      checkOutput({v.name, "_err_t1"}, bus.upd_err, 0);
      waitNeg();
      checkOutput({v.name, "_rd_t2"}, bus.q_rd_en, 0);
      checkOutput({v.name, "_we_t2"}, bus.q_we, 0);
      waitNeg();
      checkOutput({v.name, "_we_t3"}, bus.q_we, 1);
      checkOutput({v.name, "_done_t3"}, bus.upd_done, 1);
      checkOutput({v.name, "_wdata_t3"}, bus.q_wr_data, v.expWr);
      checkOutput({v.name, "_addr_t3"}, bus.q_addr, addr);
      waitNeg();
      checkOutput({v.name, "_ready_t4"}, bus.upd_ready, 1);
      checkOutput({v.name, "_done_t4"}, bus.upd_done, 0);
      checkOutput({v.name, "_mem"}, mem[addr], v.expWr);
    end
  endtask

  initial begin
    int a0;
    int a1;
    int w0;
    int w1;
    int accBase;
    int wrBase;
    int weBase;
    vec_t va;
    vec_t vb;
    vec_t vr;

    vecs[0] = '{"nominal", 6'd5,  4'd3,  16'd200,   16'd800,   16'd1000,  1'b0, 16'd975};
`ifdef QUPD_SATURATE_EN
    vecs[1] = '{"low_sat", 6'd7,  4'd0,  16'hFE0C, 16'd0,     16'd0,     1'b0, 16'd0};
    vecs[2] = '{"high_sat", 6'd9, 4'd2,  16'd32767, 16'd65535, 16'd65535, 1'b0, 16'd65535};
`else
    vecs[1] = '{"low_wrap", 6'd7, 4'd0,  16'hFE0C, 16'd0,     16'd0,     1'b0, 16'd65411};
    vecs[2] = '{"high_wrap", 6'd9, 4'd2, 16'd32767, 16'd65535, 16'd65535, 1'b0, 16'd6143};
`endif
    vecs[3] = '{"illegal", 6'd5,  4'd15, 16'd10,    16'd10,    16'd0,     1'b1, 16'd0};
    vecs[4] = '{"floor",   6'd63, 4'd14, 16'd0,     16'd8,     16'd100,   1'b0, 16'd76};
    vecs[5] = '{"wide",    6'd0,  4'd0,  16'h8000,  16'd65535, 16'd40000, 1'b0, 16'd36144};

    bus.upd_valid  = 1'b0;
    bus.upd_state  = '0;
    bus.upd_action = '0;
    bus.upd_reward = '0;
    bus.upd_max_q  = '0;

    repeat (3) @(posedge clk);
    waitNeg();
    checkOutput("reset_ready", bus.upd_ready, 0);
    checkOutput("reset_rd", bus.q_rd_en, 0);
    checkOutput("reset_we", bus.q_we, 0);
    checkOutput("reset_done", bus.upd_done, 0);
    checkOutput("reset_err", bus.upd_err, 0);
    checkOutput("reset_addr", bus.q_addr, 0);
    checkOutput("reset_wdata", bus.q_wr_data, 0);
    rst_n = 1'b1;
    waitNeg();
    checkOutput("ready_after_release", bus.upd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i]);
    end

    // Back-to-back: valid stays high across two requests
    va = '{"b2b_a", 6'd1, 4'd1, 16'd200, 16'd800, 16'd1000, 1'b0, 16'd975};
    vb = '{"b2b_b", 6'd2, 4'd2, 16'd100, 16'd0,   16'd0,    1'b0, 16'd25};
    preload({va.st, va.act}, va.ramOld);
    preload({vb.st, vb.act}, vb.ramOld);
    waitNeg();
    accBase = accCyc.size();
    wrBase  = wrCyc.size();
    bus.upd_valid  = 1'b1;
    bus.upd_state  = va.st;
    bus.upd_action = va.act;
    bus.upd_reward = va.rew;
    bus.upd_max_q  = va.mq;
    @(posedge clk);
    #1;
    bus.upd_state  = vb.st;
    bus.upd_action = vb.act;
    bus.upd_reward = vb.rew;
    bus.upd_max_q  = vb.mq;
    for (int i = 0; i < 20; i++) begin
      waitNeg();
      if (accCyc.size() >= accBase + 2) break;
    end
    bus.upd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wrCyc.size() >= wrBase + 2) break;
      waitNeg();
    end
    waitNeg();
    checkOutput("b2b_accept_count", accCyc.size() - accBase, 2);
    checkOutput("b2b_write_count", wrCyc.size() - wrBase, 2);
    a0 = (accCyc.size() > accBase)     ? accCyc[accBase]     : -100;
    a1 = (accCyc.size() > accBase + 1) ? accCyc[accBase + 1] : -100;
    w0 = (wrCyc.size() > wrBase)       ? wrCyc[wrBase]       : -100;
    w1 = (wrCyc.size() > wrBase + 1)   ? wrCyc[wrBase + 1]   : -100;
    checkOutput("b2b_second_accept_t4", a1 - a0, 4);
    checkOutput("b2b_first_write_t3", w0 - a0, 3);
    checkOutput("b2b_second_write_t7", w1 - a0, 7);
    checkOutput("b2b_mem_a", mem[{va.st, va.act}], va.expWr);
    checkOutput("b2b_mem_b", mem[{vb.st, vb.act}], vb.expWr);

    // Reset asserted during CALC must abort without a write
    vr = '{"rst_mid", 6'd3, 4'd4, 16'd400, 16'd0, 16'd500, 1'b0, 16'd475};
    preload({vr.st, vr.act}, vr.ramOld);
    waitNeg();
    weBase = weCount;
    applyStimulus(vr);
    waitNeg();
    waitNeg();
    checkOutput("rst_mid_calc_rd", bus.q_rd_en, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ready", bus.upd_ready, 0);
    checkOutput("rst_mid_rd", bus.q_rd_en, 0);
    checkOutput("rst_mid_we", bus.q_we, 0);
    checkOutput("rst_mid_done", bus.upd_done, 0);
    checkOutput("rst_mid_err", bus.upd_err, 0);
    checkOutput("rst_mid_addr", bus.q_addr, 0);
    checkOutput("rst_mid_wdata", bus.q_wr_data, 0);
    waitNeg();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_mid_ready_before_clk", bus.upd_ready, 0);
    waitNeg();
    checkOutput("rst_mid_ready_after_clk", bus.upd_ready, 1);
    waitNeg();
    checkOutput("rst_mid_no_write", weCount - weBase, 0);
    checkOutput("rst_mid_mem_intact", mem[{vr.st, vr.act}], vr.ramOld);
    runVector(vr);

    checkOutput("rd_we_overlap", overlapCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_update_engine.md
Name: q_update_engine

Overview:
- Write-back end of the Q-learning datapath: consumes the registered max-Q value produced by the action-max reduction tree and updates one Q-table entry.
- Rule: Q(s,a) <= Q(s,a) + alpha*(r + gamma*maxQ' - Q(s,a)). alpha and gamma are shift-based.
- Sequential read-modify-write against a synchronous single-port Q-table RAM; one update in flight at a time.

Parameters:
- STATE_W, 6, state index width.
- NUM_ACTIONS, 15, number of valid actions (0..NUM_ACTIONS-1); must be 16 or less.
- ALPHA_SHIFT, 2, alpha = 2^-ALPHA_SHIFT.
- GAMMA_SHIFT, 3, gamma = 1 - 2^-GAMMA_SHIFT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  update request valid.
- upd_ready  out  1  engine idle, able to accept.
- upd_state  in  STATE_W  state s.
- upd_action  in  4  action a.
- upd_reward  in  16  reward r, signed two's complement.
- upd_max_q  in  16  max Q of next state, unsigned.
- q_addr  out  STATE_W+4  Q-table address = {state, action}; shared by read and write.
- q_rd_en  out  1  RAM read strobe.
- q_rd_data  in  16  RAM read data, unsigned; valid the cycle after q_rd_en.
- q_we  out  1  RAM write strobe.
- q_wr_data  out  16  new Q value.
- upd_done  out  1  one-cycle pulse when write is issued.
- upd_err  out  1  one-cycle pulse on rejected request.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; upd_ready=0 while in reset, 1 from the first clk after release. q_rd_en, q_we, upd_done, upd_err, q_addr, q_wr_data are all 0.
- Handshake: accept on a rising edge with upd_valid && upd_ready (cycle T). Capture state, action, reward and max_q into internal registers at T; later changes on the inputs are ignored.
- upd_ready=1 only in IDLE.
- FSM IDLE -> RD -> CALC -> WR -> IDLE:
  - T+1 RD: q_rd_en=1, q_addr driven.
  - T+2 CALC: capture q_rd_data as q_old; compute and register result.
  - T+3 WR: q_we=1, q_wr_data=result, q_addr unchanged, upd_done=1.
  - T+4: IDLE, upd_ready=1. A back-to-back request can be accepted at T+4, giving a throughput of 1 update per 4 cycles.
- q_addr holds its value from RD through WR. q_rd_en and q_we are never both high.
- Illegal action (upd_action >= NUM_ACTIONS): still accepted at T. At T+1, upd_err=1 for one cycle; no RAM read or write; return to IDLE at T+1, so upd_ready=1 at T+2.
- Arithmetic (all intermediates are wide enough that nothing is lost before the final step):
  - g = max_q - (max_q >> GAMMA_SHIFT), 17-bit unsigned.
  - target = sext(reward) + g, 19-bit signed.
  - diff = target - q_old, 19-bit signed.
  - delta = diff >>> ALPHA_SHIFT, arithmetic shift (rounds toward -inf).
  - new = q_old + delta, 20-bit signed; the final 16-bit result is produced per the Optional Feature.
- Reset asserted mid-operation: the FSM aborts immediately to IDLE and all strobes drop asynchronously; no partial write is ever issued after reset.
- upd_valid held high while busy has no effect; the request is held off until upd_ready.

Optional Feature:
- Macro QUPD_SATURATE_EN.
- Defined: result clamps to the unsigned range. new < 0 gives 0; new > 65535 gives 65535.
- Undefined: result = new[15:0], i.e. wraps modulo 2^16; no clamp logic is generated.

Test Plan (ALPHA_SHIFT=2, GAMMA_SHIFT=3, NUM_ACTIONS=15; RAM model with 1-cycle read):
- Nominal: RAM[{5,3}]=1000, request s=5, a=3, r=200, max_q=800. Expect q_rd_en at T+1 with addr {5,3}; q_we plus upd_done at T+3 with q_wr_data=975; upd_ready back at T+4.
- Low saturation: RAM=0, r=-500, max_q=0, new=-125. With SATURATE_EN expect write 0; without it expect 65411 (0xFF83).
- High saturation: RAM=65535, r=32767, max_q=65535, new=71679. With SATURATE_EN expect 65535; without it expect 6143.
- Illegal action: a=15. Expect upd_err pulse at T+1, no q_rd_en and no q_we, upd_ready=1 at T+2; next legal request completes normally.
- Back-to-back: upd_valid held high with two requests. Expect second accept exactly at T+4, second write at T+7, and q_rd_en/q_we never overlapping.
- Reset mid-op: drop rst_n during CALC. Expect all outputs 0 immediately and no q_we. After release, upd_ready=1 on the first clk and a new request completes normally.
